seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Sequential restoring divider: the inverse of the wide shift-add multiplier. Computes
//  quotient and remainder of two unsigned WIDTH-bit operands, one quotient bit per clock.
//  Sits beside the multiplier in the wide-arithmetic datapath; its results feed modular reduction.
//  Valid/ready handshake on both input and output sides.
// PARAMETERS
//  WIDTH    4096   operand, quotient and remainder width in bits (>=2)
//  CNT_W    $clog2(WIDTH+1)   step-counter width (derived; not overridden)
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst          in   1      synchronous, active-low reset (sampled on posedge clk)
//  in_valid     in   1      dividend/divisor valid
//  in_ready     out  1      block can accept operands (high only in IDLE)
//  a            in   WIDTH  dividend (unsigned)
//  b            in   WIDTH  divisor (unsigned)
//  out_valid    out  1      q/r/div_by_zero valid; held until out_ready
//  out_ready    in   1      downstream accepts result
//  q            out  WIDTH  quotient  floor(a/b)
//  r            out  WIDTH  remainder a mod b
//  div_by_zero  out  1      result produced with b==0
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0,
//    counter=0, internal registers cleared. Reset takes effect in any state and aborts a division.
//  - States: IDLE -> RUN -> DONE -> IDLE; IDLE -> DONE directly when b==0.
//  - IDLE: in_ready=1. Accept on posedge with in_valid&&in_ready: latch a into the dividend
//    shift register, b into the divisor register, partial remainder (WIDTH+1 bits) = 0,
//    counter = 0, next state RUN. If b==0: q=all ones, r=a, div_by_zero=1, next state DONE.
//  - RUN: each posedge performs one step: rem' = {rem[WIDTH-1:0], dvd[WIDTH-1]}; dvd shifts
//    left by 1; if rem' >= {1'b0,b} then rem' -= b and the quotient bit shifted in = 1, else 0.
//    counter++; on step WIDTH (counter==WIDTH-1) latch q, r=rem'[WIDTH-1:0],
//    div_by_zero=0, next state DONE. Inputs a/b/in_valid are ignored during RUN.
//  - Latency: out_valid high after exactly WIDTH+1 posedges, counting the accept edge
//    (1 edge for b==0).
//  - DONE: out_valid=1; q, r and div_by_zero are held stable while out_ready==0. Posedge with
//    out_valid&&out_ready -> IDLE; out_valid drops and in_ready rises on the same edge.
//    There is no same-cycle re-accept: a new operand pair is accepted no earlier than the next edge.
//  - q/r are registered outputs; they retain the last result in IDLE until the next result is latched.
//  - Width rule: remainder datapath is WIDTH+1 bits so the compare never overflows. Subtract
//    result fits in WIDTH bits. No signed support.
//  - Remainder invariant: r < b whenever b != 0; a == q*b + r.
// STRUCTURE
//  - Package seq_divider_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t.
//  - One sub-module, div_step: purely combinational single restoring step
//    (rem_in, dvd_msb, b -> rem_out, q_bit), parameterised by WIDTH.
//  - Top: FSM, step counter (CNT_W), dividend/quotient shift register, remainder register, output regs.
// TESTING  (WIDTH=8 unless noted)
//  - a=200, b=7, out_ready=1 -> out_valid on 9th edge after accept; q=28, r=4, dbz=0.
//  - a=5, b=9 -> q=0, r=5; a=255, b=1 -> q=255, r=0; a=255, b=255 -> q=1, r=0.
//  - a=37, b=0 -> out_valid 1 edge after accept; q=8'hFF, r=37, dbz=1; no RUN cycles.
//  - Backpressure: out_ready=0 for 5 cycles after out_valid -> q/r/dbz stable, in_ready=0;
//    in_valid pulsed during RUN/DONE is ignored. Then out_ready=1 -> IDLE next edge.
//  - Reset mid-RUN (rst=0 at step 4 of a=200,b=7) -> next edge: IDLE, out_valid=0, q=r=0;
//    new a=100,b=10 -> q=10, r=0.
//  - WIDTH=4096 smoke test: a=2^4095, b=2^2048 -> q=2^2047, r=0 after 4097 edges;
//    plus 1000 random pairs checked against the invariant a==q*b+r, r<b.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_divider_div_step #(
    parameter int unsigned WIDTH = 4096
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // One extra bit so the shifted remainder can exceed any WIDTH-bit divisor.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] b_ext;

    always_comb begin
        rem_shift = {rem_i, dvd_msb_i};
        b_ext     = {1'b0, b_i};
        q_bit_o   = (rem_shift >= b_ext);
        // After a successful subtract the result is < b, so it always fits in WIDTH bits.
        rem_o     = q_bit_o ? WIDTH'(rem_shift - b_ext) : rem_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             div_by_zero_o
);

    localparam int unsigned     CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q_bit;

    seq_divider_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .dvd_msb_i(dvd_q[WIDTH-1]),
        .b_i      (b_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    dvd_d = a_i;
                    b_d   = b_i;
                    rem_d = '0;
                    cnt_d = '0;
                    if (b_i == '0) begin
                        q_d     = '1;
                        r_d     = a_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], step_q_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    q_d     = {dvd_q[WIDTH-2:0], step_q_bit};
                    r_d     = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign out_valid_o   = (state_q == DONE);
    assign q_o           = q_q;
    assign r_o           = r_q;
    assign div_by_zero_o = dbz_q;

endmodule
